// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Default backing-memory access time in cycles (legal range 1..15).
    localparam int unsigned LATENCY_DEFAULT = 4;

    // Width of the access-cycle counter; 15 cycles is the longest legal access.
    localparam int unsigned CNT_W = 4;

    // Owner encoding shared by the arbiter and anything that inspects it.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StRespond = 2'd2
    } arb_state_e;

    // Single requester wins outright; on contention the data port wins unless it
    // also won last time, which gives strict alternation under sustained load.
    function automatic logic pick_owner(input logic if_req, input logic dm_req,
                                        input logic last_owner);
        logic owner;
        if (if_req && dm_req) begin
            owner = (last_owner == OWN_DM) ? OWN_IF : OWN_DM;
        end else if (dm_req) begin
            owner = OWN_DM;
        end else begin
            owner = OWN_IF;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory between instruction fetch
// and data access. One access in flight at a time: IDLE -> ACCESS -> RESPOND.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,

    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_stall,

    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             last_q;
    logic [15:0]      addr_q;
    logic [15:0]      wdata_q;
    logic             wr_q;
    logic [15:0]      rdata_q;

    logic             grant;
    logic             grant_owner;
    logic             last_access;

    // Requests are only looked at in IDLE; anything seen elsewhere waits.
    assign grant       = (state_q == StIdle) && (if_req || dm_req);
    assign grant_owner = pick_owner(if_req, dm_req, last_q);
    assign last_access = (state_q == StAccess) && (cnt_q == CNT_LAST);

    // State register; reset abandons any in-flight access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (last_access) begin
                    state_d = StRespond;
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Access-cycle counter: cleared on grant, counts through ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (grant) begin
            cnt_q <= '0;
        end else if (state_q == StAccess) begin
            cnt_q <= last_access ? '0 : cnt_q + 1'b1;
        end
    end

    // Latch the winning request so the memory sees stable values all access long.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_IF;
            last_q  <= OWN_IF;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            wr_q    <= 1'b0;
        end else if (grant) begin
            owner_q <= grant_owner;
            last_q  <= grant_owner;
            if (grant_owner == OWN_DM) begin
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
                wr_q    <= dm_wr;
            end else begin
                addr_q  <= if_addr;
                wdata_q <= 16'h0000;
                wr_q    <= 1'b0;
            end
        end
    end

    // Capture the memory word on the final access cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 16'h0000;
        end else if (last_access) begin
            rdata_q <= mem_rdata;
        end
    end

    // Outputs decoded from state; everything idles at zero outside its window.
    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;
        if_valid   = 1'b0;
        if_rdata   = 16'h0000;
        dm_valid   = 1'b0;
        dm_rdata   = 16'h0000;
        unique case (state_q)
            StAccess: begin
                mem_enable = 1'b1;
                mem_wr     = wr_q;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
            end
            StRespond: begin
                if (owner_q == OWN_IF) begin
                    if_valid = 1'b1;
                    if_rdata = rdata_q;
                end else begin
                    dm_valid = 1'b1;
                    // Stores return nothing; the captured word is meaningless.
                    dm_rdata = wr_q ? 16'h0000 : rdata_q;
                end
            end
            default: begin
            end
        endcase
    end

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    // Completion pulses belong to one owner only.
    assert property (@(posedge clk) disable iff (rst) !(if_valid && dm_valid));

    // Memory-side signals must not change in the middle of an access.
    assert property (@(posedge clk) disable iff (rst)
        (state_q == StAccess && !last_access) |=>
            ($stable(mem_addr) && $stable(mem_wdata) && $stable(mem_wr) && mem_enable));

    // Every access is followed by exactly one response cycle.
    assert property (@(posedge clk) disable iff (rst)
        last_access |=> (state_q == StRespond));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.LATENCY(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .if_stall   (if_stall),
        .dm_req     (dm_req),
        .dm_wr      (dm_wr),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_valid   (dm_valid),
        .dm_stall   (dm_stall),
        .mem_enable (mem_enable),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: unwritten words read as a fixed pattern, 0x0010 holds 0xBEEF.
    logic [15:0] mem     [0:255];
    bit          written [0:255];

    function automatic logic [15:0] base_word(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : {8'hA5, a[7:0]};
    endfunction

    assign mem_rdata = written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : base_word(mem_addr);

    always @(posedge clk) begin
        if (mem_enable && mem_wr) begin
            mem[mem_addr[7:0]]     <= mem_wdata;
            written[mem_addr[7:0]] <= 1'b1;
        end
    end

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        dm_req;
        logic        dm_wr;
        logic [15:0] dm_addr;
        logic [15:0] dm_wdata;
        logic        en;
        logic        wr;
        logic [15:0] maddr;
        logic [15:0] mwdata;
        logic        ifv;
        logic [15:0] ifr;
        logic        ifs;
        logic        dmv;
        logic [15:0] dmr;
        logic        dms;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ireq, input logic [15:0] iaddr, input logic dreq,
                       input logic dwr, input logic [15:0] daddr, input logic [15:0] dwd,
                       input logic en, input logic wr, input logic [15:0] maddr,
                       input logic [15:0] mwd, input logic ifv, input logic [15:0] ifr,
                       input logic ifs, input logic dmv, input logic [15:0] dmr,
                       input logic dms);
        vec_t v;
        v.if_req = ireq; v.if_addr = iaddr; v.dm_req = dreq; v.dm_wr = dwr;
        v.dm_addr = daddr; v.dm_wdata = dwd; v.en = en; v.wr = wr; v.maddr = maddr;
        v.mwdata = mwd; v.ifv = ifv; v.ifr = ifr; v.ifs = ifs; v.dmv = dmv; v.dmr = dmr;
        v.dms = dms;
        vecs.push_back(v);
    endtask

    // Enter a new cycle: inputs change just after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
        #2;
        next_cycle();
        rst = 1'b0;
    endtask

    // Count rising edges from the current cycle to the next valid pulse; -1 on timeout.
    task automatic wait_valid(input int budget, output int cycles, output logic got_if,
                              output logic got_dm);
        cycles = -1;
        got_if = 1'b0;
        got_dm = 1'b0;
        for (int c = 0; c <= budget; c++) begin
            @(negedge clk);
            if (if_valid || dm_valid) begin
                cycles = c;
                got_if = if_valid;
                got_dm = dm_valid;
                break;
            end
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   nv;
        int   nen;
        logic gi, gd;

        // Reset state.
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
        @(negedge clk);
        check1("rst mem_enable", mem_enable, 1'b0);
        check1("rst mem_wr", mem_wr, 1'b0);
        check16("rst mem_addr", mem_addr, 16'h0000);
        check1("rst if_valid", if_valid, 1'b0);
        check1("rst dm_valid", dm_valid, 1'b0);
        check16("rst dm_rdata", dm_rdata, 16'h0000);
        next_cycle();
        rst = 1'b0;

        // Fetch from 0x0010 (0xBEEF).
        add(1, 16'h0010, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1,  0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(1, 16'h0010, 0, 0, 0, 0,  1, 0, 16'h0010, 0,  0, 0, 1,  0, 0, 0);
        add(1, 16'h0010, 0, 0, 0, 0,  0, 0, 0, 0,  1, 16'hBEEF, 0,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        // Store 0x1234 to 0x0020.
        add(0, 0, 1, 1, 16'h0020, 16'h1234,  0, 0, 0, 0,  0, 0, 0,  0, 0, 1);
        for (int i = 0; i < 4; i++)
            add(0, 0, 1, 1, 16'h0020, 16'h1234,  1, 1, 16'h0020, 16'h1234,  0, 0, 0,  0, 0, 1);
        add(0, 0, 1, 1, 16'h0020, 16'h1234,  0, 0, 0, 0,  0, 0, 0,  1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        // Load 0x0020 back.
        add(0, 0, 1, 0, 16'h0020, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 1);
        for (int i = 0; i < 4; i++)
            add(0, 0, 1, 0, 16'h0020, 0,  1, 0, 16'h0020, 0,  0, 0, 0,  0, 0, 1);
        add(0, 0, 1, 0, 16'h0020, 0,  0, 0, 0, 0,  0, 0, 0,  1, 16'h1234, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0);

        foreach (vecs[i]) begin
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            dm_req = vecs[i].dm_req; dm_wr = vecs[i].dm_wr;
            dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
            @(negedge clk);
            check1($sformatf("v%0d mem_enable", i), mem_enable, vecs[i].en);
            check1($sformatf("v%0d mem_wr", i), mem_wr, vecs[i].wr);
            check16($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
            check16($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].mwdata);
            check1($sformatf("v%0d if_valid", i), if_valid, vecs[i].ifv);
            check16($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].ifr);
            check1($sformatf("v%0d if_stall", i), if_stall, vecs[i].ifs);
            check1($sformatf("v%0d dm_valid", i), dm_valid, vecs[i].dmv);
            check16($sformatf("v%0d dm_rdata", i), dm_rdata, vecs[i].dmr);
            check1($sformatf("v%0d dm_stall", i), dm_stall, vecs[i].dms);
            next_cycle();
        end

        // Contention from reset: data first, fetch 6 cycles after dm_valid.
        do_reset();
        if_req = 1'b1; if_addr = 16'h0010;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0030;
        wait_valid(40, cyc, gi, gd);
        check_int("contend dm latency", cyc, 5);
        check1("contend first dm", gd, 1'b1);
        check1("contend first not if", gi, 1'b0);
        check16("contend dm_rdata", dm_rdata, 16'hA530);
        next_cycle();
        dm_req = 1'b0;
        wait_valid(40, cyc, gi, gd);
        check_int("contend if gap", cyc + 1, 6);
        check1("contend second if", gi, 1'b1);
        check16("contend if_rdata", if_rdata, 16'hBEEF);
        next_cycle();
        if_req = 1'b0;

        // Sustained contention alternates dm, if, dm, if.
        do_reset();
        if_req = 1'b1; if_addr = 16'h0010;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            wait_valid(40, cyc, gi, gd);
            check_int($sformatf("alt%0d latency", k), cyc, 5);
            check1($sformatf("alt%0d dm owner", k), gd, (k % 2) == 0);
            check1($sformatf("alt%0d if owner", k), gi, (k % 2) == 1);
            if ((k % 2) == 0) check16($sformatf("alt%0d dm_rdata", k), dm_rdata, 16'h1234);
            else              check16($sformatf("alt%0d if_rdata", k), if_rdata, 16'hBEEF);
            next_cycle();
        end
        if_req = 1'b0; dm_req = 1'b0;
        next_cycle();

        // Reset in the second access cycle abandons the fetch at once.
        if_req = 1'b1; if_addr = 16'h0010;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check1("midrst enable before", mem_enable, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check1("midrst enable async", mem_enable, 1'b0);
        check16("midrst addr async", mem_addr, 16'h0000);
        if_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if_valid || dm_valid) nv++;
            next_cycle();
        end
        check_int("midrst no valid", nv, 0);
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
        wait_valid(40, cyc, gi, gd);
        check_int("postrst latency", cyc, 5);
        check1("postrst dm_valid", gd, 1'b1);
        check16("postrst dm_rdata", dm_rdata, 16'h1234);
        next_cycle();
        dm_req = 1'b0;

        // Fetch request withdrawn mid-access still completes exactly once.
        if_req = 1'b1; if_addr = 16'h0040;
        next_cycle();
        next_cycle();
        if_req = 1'b0;
        wait_valid(40, cyc, gi, gd);
        check_int("drop remaining", cyc, 3);
        check1("drop if_valid", gi, 1'b1);
        check16("drop if_rdata", if_rdata, 16'hA540);
        check1("drop if_stall", if_stall, 1'b0);
        next_cycle();
        nv = 0;
        nen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if_valid || dm_valid) nv++;
            if (mem_enable) nen++;
            next_cycle();
        end
        check_int("drop no more valid", nv, 0);
        check_int("drop no new grant", nen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning backing-memory access cycles (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, held until if_valid.
REQ-005 SHALL have port if_addr  input  16  fetch address.
REQ-006 SHALL have port if_rdata  output  16  fetched word, valid while if_valid.
REQ-007 SHALL have port if_valid  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port if_stall  output  1  fetch stall to pipeline.
REQ-009 SHALL have port dm_req  input  1  data-memory request, held until dm_valid.
REQ-010 SHALL have port dm_wr  input  1  1 = store, 0 = load.
REQ-011 SHALL have port dm_addr  input  16  data address.
REQ-012 SHALL have port dm_wdata  input  16  store data.
REQ-013 SHALL have port dm_rdata  output  16  load data, valid while dm_valid.
REQ-014 SHALL have port dm_valid  output  1  one-cycle data completion pulse.
REQ-015 SHALL have port dm_stall  output  1  data stall to pipeline.
REQ-016 SHALL have ports mem_enable (output 1), mem_wr (output 1), mem_addr (output 16), mem_wdata (output 16), mem_rdata (input 16) to the single shared memory.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESPOND; IDLE->ACCESS on grant, ACCESS->RESPOND after LATENCY cycles, RESPOND->IDLE unconditionally.
REQ-018 SHALL sample requests only in IDLE; grant latches owner, address, wdata, wr into internal registers.
REQ-019 SHALL grant per arbitration: only one requester -> that one; both -> dm, unless last grant was dm, then if.
REQ-020 SHALL drive mem_enable=1 and mem_addr/mem_wdata/mem_wr from latched values for exactly LATENCY cycles in ACCESS, stable throughout; mem_wr=0 for loads and for all if accesses.
REQ-021 SHALL drive mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0 outside ACCESS.
REQ-022 SHALL capture mem_rdata on the last ACCESS cycle (counter == LATENCY-1).
REQ-023 SHALL assert owner's valid only in RESPOND; request sampled in IDLE at cycle t gives valid at cycle t+LATENCY+1.
REQ-024 SHALL present captured word on owner's rdata in RESPOND; dm_rdata SHALL be 0x0000 for stores; non-owner rdata SHALL be 0x0000.
REQ-025 SHALL compute if_stall = if_req & ~if_valid and dm_stall = dm_req & ~dm_valid combinationally.
REQ-026 SHALL complete an access even if its requester deasserts request mid-access; valid still pulses, no retry.
REQ-027 SHALL not grant in RESPOND; a request still high there is treated as new in the following IDLE.
REQ-028 SHALL use a counter width of 4 bits; counter reloads to 0 on every grant.

Reset
REQ-029 SHALL on rst go to IDLE immediately, abandoning any in-flight access; mem_enable drops without waiting for clk.
REQ-030 SHALL reset all outputs to 0, counter to 0, latched address/data/rdata to 0x0000, last-grant to if (so first contention goes to dm).

Structure
REQ-031 SHALL place the state enum, owner encoding (OWN_IF=0, OWN_DM=1) and LATENCY default in shared package mem_arb_pkg.
REQ-032 SHALL be a single module with no sub-modules; the shared memory (memory1c) is instantiated by the parent, not inside.

Verification
REQ-033 SHALL cover: LATENCY=4, if_req, if_addr=0x0010, memory word 0xBEEF -> mem_enable 4 cycles at 0x0010, if_valid at t+5 with 0xBEEF, if_stall high t..t+4.
REQ-034 SHALL cover: dm_req store, dm_addr=0x0020, dm_wdata=0x1234 -> mem_wr=1 for 4 cycles, dm_valid at t+5, dm_rdata=0x0000; later load 0x0020 returns 0x1234.
REQ-035 SHALL cover: if_req and dm_req together from reset -> dm served first, if granted next IDLE, if_valid 6 cycles after dm_valid.
REQ-036 SHALL cover: dm_req held continuously with if_req -> grants alternate dm, if, dm, if; no starvation.
REQ-037 SHALL cover: rst asserted mid-ACCESS (cycle 2 of 4) -> mem_enable 0 before next edge, no valid pulse, fresh request after release completes normally.
REQ-038 SHALL cover: if_req dropped during ACCESS -> if_valid still pulses once, next IDLE grants nothing.
